// File: rtl/unaligned_store_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | unaligned_store_packer                                                   |
// | Rotates source beats to a destination byte offset, carries spill bytes   |
// | into the next memory beat and emits byte strobes. Optional macro:        |
// | PACKER_REVERSE_EN (adds reverse input, off = (NB - dst_offset) mod NB).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module unaligned_store_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 8,
  localparam int NB = DATA_WIDTH / WORD_WIDTH,
  localparam int OW = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [OW-1:0]         in_bytes,
  input  logic [OW-1:0]         dst_offset,
`ifdef PACKER_REVERSE_EN
  input  logic                  reverse,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NB-1:0]         out_strb,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         off_q, off_d;
  logic [DATA_WIDTH-1:0] carry_data_q, carry_data_d;
  logic [NB-1:0]         carry_strb_q, carry_strb_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NB-1:0]         out_strb_q, out_strb_d;
  logic                  out_last_q, out_last_d;

  logic [OW-1:0]           new_off, cur_off;
  logic [OW:0]             nbytes;
  logic                    spill, accept, can_load;
  logic [NB-1:0]           lo_lanes, src_strb, rot_strb, load_strb, carry_strb_n, carry_strb_eff;
  logic [DATA_WIDTH-1:0]   rot_data, load_data, carry_data_n, carry_data_eff;
  logic [2*DATA_WIDTH-1:0] rot_data_wide;
  logic [2*NB-1:0]         rot_strb_wide;

`ifdef PACKER_REVERSE_EN
  assign new_off = reverse ? (OW'(0) - dst_offset) : dst_offset;
`else
  assign new_off = dst_offset;
`endif

  // The first beat of a packet uses the offset presented with it, not the latched one.
  assign cur_off  = (state_q == S_IDLE) ? new_off : off_q;
  assign nbytes   = (in_bytes == '0) ? (OW+1)'(NB) : {1'b0, in_bytes};
  assign spill    = ({1'b0, cur_off} + nbytes) > (OW+1)'(NB);
  assign can_load = !out_valid_q || out_ready;
  assign in_ready = (state_q != S_FLUSH) && can_load;
  assign accept   = in_valid && in_ready;

  assign carry_data_eff = (state_q == S_IDLE) ? '0 : carry_data_q;
  assign carry_strb_eff = (state_q == S_IDLE) ? '0 : carry_strb_q;

  always_comb begin
    lo_lanes = '0;
    src_strb = '0;
    for (int i = 0; i < NB; i++) begin
      lo_lanes[i] = OW'(i) < cur_off;
      src_strb[i] = !in_last || ((OW+1)'(i) < nbytes);
    end
  end

  assign rot_data_wide = {in_data, in_data} << (cur_off * WORD_WIDTH);
  assign rot_data      = rot_data_wide[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign rot_strb_wide = {src_strb, src_strb} << cur_off;
  assign rot_strb      = rot_strb_wide[2*NB-1 -: NB];

  // Lanes below the offset come from the carry; their new rotated bytes become the next carry.
  always_comb begin
    load_data    = '0;
    load_strb    = '0;
    carry_data_n = '0;
    carry_strb_n = '0;
    for (int i = 0; i < NB; i++) begin
      if (lo_lanes[i]) begin
        load_strb[i] = carry_strb_eff[i];
        load_data[i*WORD_WIDTH +: WORD_WIDTH] = carry_data_eff[i*WORD_WIDTH +: WORD_WIDTH];
        carry_strb_n[i] = rot_strb[i];
        if (rot_strb[i]) carry_data_n[i*WORD_WIDTH +: WORD_WIDTH] = rot_data[i*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        load_strb[i] = rot_strb[i];
        if (rot_strb[i]) load_data[i*WORD_WIDTH +: WORD_WIDTH] = rot_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    carry_data_d = carry_data_q;
    carry_strb_d = carry_strb_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    out_last_d   = out_last_q;
    if (out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = load_data;
      out_strb_d   = load_strb;
      off_d        = cur_off;
      carry_data_d = carry_data_n;
      carry_strb_d = carry_strb_n;
      if (in_last) begin
        out_last_d = !spill;
        state_d    = spill ? S_FLUSH : S_IDLE;
        if (!spill) begin
          carry_data_d = '0;
          carry_strb_d = '0;
        end
      end else begin
        out_last_d = 1'b0;
        state_d    = S_STREAM;
      end
    end else if (state_q == S_FLUSH && can_load) begin
      out_valid_d  = 1'b1;
      out_data_d   = carry_data_q;
      out_strb_d   = carry_strb_q;
      out_last_d   = 1'b1;
      carry_data_d = '0;
      carry_strb_d = '0;
      state_d      = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      off_q        <= '0;
      carry_data_q <= '0;
      carry_strb_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      carry_data_q <= carry_data_d;
      carry_strb_q <= carry_strb_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_strb  = out_strb_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_unaligned_store_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_unaligned_store_packer                                                |
// | Byte-address scoreboard bench for unaligned_store_packer.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_unaligned_store_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [2:0]  in_bytes = '0;
  logic [2:0]  dst_offset = '0;
`ifdef PACKER_REVERSE_EN
  logic        reverse = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_strb;
  logic        out_last;

  unaligned_store_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .dst_offset (dst_offset),
`ifdef PACKER_REVERSE_EN
    .reverse    (reverse),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_strb   (out_strb),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       e;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          stall_seen = 1'b0;
  logic [63:0] prev_d;
  logic [7:0]  prev_s;
  logic        prev_l;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory view: stream byte k lands at address off+k; beat n covers addresses 8n..8n+7.
  task automatic push_expected(input int off, input logic [7:0] q[$]);
    int total = q.size();
    int nout  = (off + total + 7) / 8;
    for (int k = 0; k < nout; k++) begin
      beat_t b;
      b.d = '0;
      b.s = '0;
      b.l = (k == nout - 1);
      for (int l = 0; l < 8; l++) begin
        int pos = 8 * k + l - off;
        if (pos >= 0 && pos < total) begin
          b.d[8*l +: 8] = q[pos];
          b.s[l] = 1'b1;
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [2:0] nb,
                           input logic [2:0] off, input logic rv);
    bit hs = 1'b0;
    int guard = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_last    = last;
    in_bytes   = nb;
    dst_offset = off;
`ifdef PACKER_REVERSE_EN
    reverse    = rv;
`else
    if (rv) $display("reverse ignored in this build");
`endif
    while (!hs && guard < 1000) begin
      #1 hs = in_ready;
      @(posedge clk);
      if (!hs) begin
        @(negedge clk);
        guard++;
      end
    end
    @(negedge clk);
    in_valid   = 1'b0;
    in_data    = {$urandom, $urandom};
    dst_offset = 3'($urandom);
    chk("accept_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_packet_q(input int doff, input bit rv, input logic [7:0] q[$], input bit gaps);
    int eff   = rv ? (8 - doff) % 8 : doff;
    int total = q.size();
    int nb    = (total + 7) / 8;
    push_expected(eff, q);
    for (int j = 0; j < nb; j++) begin
      logic [63:0] d = {$urandom, $urandom};
      bit          last = (j == nb - 1);
      for (int l = 0; l < 8; l++)
        if (8 * j + l < total) d[8*l +: 8] = q[8*j + l];
      send_beat(d, last, last ? 3'((total - 8 * j) % 8) : 3'($urandom),
                (j == 0) ? 3'(doff) : 3'($urandom), (j == 0) ? rv : 1'($urandom));
      if (gaps) repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  task automatic send_random(input int doff, input bit rv, input int nbeats, input int lastb, input bit gaps);
    logic [7:0] q[$];
    for (int k = 0; k < (nbeats - 1) * 8 + lastb; k++) q.push_back(8'($urandom));
    send_packet_q(doff, rv, q, gaps);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain_pending_beats", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready) out_ready = ($urandom_range(3) != 0);
    end
  end

  // Scoreboard and hold-stability checker, sampled just after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (stall_seen && out_valid) begin
          chk("hold_data", out_data, prev_d);
          chk("hold_strb", 64'(out_strb), 64'(prev_s));
          chk("hold_last", 64'(out_last), 64'(prev_l));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'd0);
          end else if (out_valid) begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_strb", 64'(out_strb), 64'(e.s));
            chk("out_last", 64'(out_last), 64'(e.l));
          end
        end
        stall_seen = out_valid && !out_ready;
        prev_d = out_data;
        prev_s = out_strb;
        prev_l = out_last;
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_strb", 64'(out_strb), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    mon_en = 1'b1;

    // off=0 pass-through, two full beats
    send_random(0, 1'b0, 2, 8, 1'b0);
    drain();

    // off=3 single beat with flush beat
    q = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    send_packet_q(3, 1'b0, q, 1'b0);
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    drain();

    // off=5, last beat 2 bytes: no flush
    send_random(5, 1'b0, 2, 2, 1'b0);
    drain();

    // off=3 stream with a 3-cycle stall mid-packet
    fork
      send_random(3, 1'b0, 5, 4, 1'b0);
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) begin
          #1;
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // reset in the middle of a packet with live carry
    mon_en = 1'b0;
    send_beat({$urandom, $urandom} | 64'h0000_0000_00FF_FFFF, 1'b0, 3'd0, 3'd3, 1'b0);
    #1 chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
    chk("mid_reset_out_strb", 64'(out_strb), 64'd0);
    chk("mid_reset_out_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    send_random(0, 1'b0, 2, 8, 1'b0);
    send_random(3, 1'b0, 1, 8, 1'b0);
    drain();

    // randomized traffic with gaps and random backpressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
`ifdef PACKER_REVERSE_EN
      send_random($urandom_range(7), 1'($urandom), $urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
`else
      send_random($urandom_range(7), 1'b0, $urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
`endif
    end
    rnd_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

`ifdef PACKER_REVERSE_EN
    send_random(3, 1'b1, 2, 8, 1'b0);
    send_random(0, 1'b1, 1, 8, 1'b0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
